dmem_responder: RTL and testbench

- Data-memory responder for the RV32 core's load/store port.
- Accepts one load/store request per transaction over a valid/ready handshake.
- Inserts a configurable number of wait states, then accesses an internal word-organised RAM.
- Returns read data (sign/zero-extended per funct3) or a store acknowledgement over a second valid/ready handshake.

---
 rtl/dmem_responder.sv | 206 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Data-memory responder for an RV32 load/store port. Accepts one
//            request over a valid/ready handshake, spends WAIT_STATES cycles
//            in BUSY, accesses an internal word-organised RAM, and returns
//            sign/zero-extended load data or a store acknowledgement over a
//            second valid/ready handshake.
// Ports    : clk                      - clock, rising edge
//            reset                    - synchronous, active-low reset
//            req_valid / req_ready    - request handshake
//            req_we, req_addr, req_wdata, req_funct3 - request payload
//            rsp_valid / rsp_ready    - response handshake
//            rsp_rdata, rsp_err       - response payload
// Macro    : DMEM_ERR_EN - when defined, misaligned, out-of-range and
//            illegal-funct3 requests are rejected with rsp_err=1. When
//            undefined, addresses are force-aligned, wrap modulo DEPTH, and
//            illegal funct3 is treated as a word access.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_STATES);
`ifdef DMEM_ERR_EN
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH) * 33'd4;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            we_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [2:0]      f3_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_rdata_q;
  logic            rsp_err_q;
  logic [31:0]     rd_word_q;
  logic [31:0]     mem_q [DEPTH];

  logic [31:0]     off_w;
  logic [AW-1:0]   idx_w;
  logic            f3_legal_w;
  logic [2:0]      f3_eff_w;
  logic [1:0]      lane_w;
  logic            err_w;
  logic [3:0]      be_w;
  logic [31:0]     wdata_rep_w;
  logic [7:0]      byte_w;
  logic [15:0]     half_w;
  logic [31:0]     rdata_d;
  logic            access_w;

  assign req_ready = (state_q == IDLE) && reset;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Decode works on the captured request, which stays stable until the next
  // accept, so it is valid both at the access edge and while in RESP.
  assign off_w      = addr_q - ADDR_BASE;
  assign idx_w      = AW'((off_w >> 2) % DEPTH);
  assign f3_legal_w = we_q ? (f3_q inside {3'b000, 3'b001, 3'b010})
                           : (f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

`ifdef DMEM_ERR_EN
  assign f3_eff_w = f3_q;
  assign err_w    = !f3_legal_w
                 || ((f3_q[1:0] == 2'b01) && addr_q[0])
                 || ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00))
                 || (addr_q < ADDR_BASE)
                 || ({1'b0, off_w} >= RAM_BYTES);
`else
  assign f3_eff_w = f3_legal_w ? f3_q : 3'b010;
  assign err_w    = 1'b0;
`endif

  // Lane is forced to the access alignment; for legal aligned requests this
  // equals addr[1:0], so the same expression serves both builds.
  always_comb begin
    case (f3_eff_w[1:0])
      2'b00:   lane_w = addr_q[1:0];
      2'b01:   lane_w = {addr_q[1], 1'b0};
      default: lane_w = 2'b00;
    endcase
  end

  always_comb begin
    case (f3_eff_w[1:0])
      2'b00: begin
        be_w        = 4'b0001 << lane_w;
        wdata_rep_w = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_w        = lane_w[1] ? 4'b1100 : 4'b0011;
        wdata_rep_w = {2{wdata_q[15:0]}};
      end
      default: begin
        be_w        = 4'b1111;
        wdata_rep_w = wdata_q;
      end
    endcase
  end

  always_comb begin
    case (lane_w)
      2'd0:    byte_w = rd_word_q[7:0];
      2'd1:    byte_w = rd_word_q[15:8];
      2'd2:    byte_w = rd_word_q[23:16];
      default: byte_w = rd_word_q[31:24];
    endcase
    half_w = lane_w[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    case (f3_eff_w)
      3'b000:  rdata_d = {{24{byte_w[7]}}, byte_w};
      3'b001:  rdata_d = {{16{half_w[15]}}, half_w};
      3'b100:  rdata_d = {24'h0, byte_w};
      3'b101:  rdata_d = {16'h0, half_w};
      default: rdata_d = rd_word_q;
    endcase
    if (err_w || we_q) begin
      rdata_d = 32'h0;
    end
  end

  // The access edge is the BUSY exit; reset low at that edge cancels it.
  assign access_w = reset && (state_q == BUSY) && (cnt_q == '0);

  // RAM: registered read and byte-masked write, never reset.
  always_ff @(posedge clk) begin
    if (access_w) begin
      rd_word_q <= mem_q[idx_w];
      if (we_q && !err_w) begin
        for (int b = 0; b < 4; b++) begin
          if (be_w[b]) begin
            mem_q[idx_w][8*b +: 8] <= wdata_rep_w[8*b +: 8];
          end
        end
      end
    end
  end

  // Control FSM. The RAM read is registered at the BUSY exit, so the
  // response registers load on the first RESP edge (WAIT_STATES+2 latency).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            f3_q    <= req_funct3;
            cnt_q   <= CNT_INIT;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= err_w;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Directed self-checking bench for dmem_responder (default
//            parameters: DEPTH=1024, WAIT_STATES=2, ADDR_BASE=0). Error
//            scenarios follow the DMEM_ERR_EN build setting.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  // Runs one transaction with rsp_ready high. lat = edges from accept to
  // rsp_valid high (50 means no response). Caller is at posedge+1.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] f3, output logic [31:0] rdata,
                      output logic err, output int lat);
    int n;
    req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    rdata = rsp_rdata;
    err   = rsp_err;
    if (rsp_valid && rsp_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_funct3 = '0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b want 0", req_ready); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else passed++;
    total++; if (rsp_rdata !== 32'h0) $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); else passed++;
    @(posedge clk); @(posedge clk); #1;
    total++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready_late: got %b want 0", req_ready); else passed++;
    reset = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", req_ready); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_word;
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er, lat);
    total++; if (lat !== 4) $display("FAIL sw_latency: got %0d want 4", lat); else passed++;
    total++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL sw_rsp: rdata=%h err=%b want 0/0", rd, er); else passed++;
    xact(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
    total++; if (lat !== 4) $display("FAIL lw_latency: got %0d want 4", lat); else passed++;
    total++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_10: got %h want deadbeef", rd); else passed++;
    total++; if (er !== 1'b0) $display("FAIL lw_10_err: got %b want 0", er); else passed++;
  endtask

  task automatic test_subword;
    logic [31:0] rd; logic er; int lat;
    xact(1'b0, 32'h13, 32'h0, 3'b000, rd, er, lat);
    total++; if (rd !== 32'hFFFFFFDE) $display("FAIL lb_13: got %h want ffffffde", rd); else passed++;
    xact(1'b0, 32'h13, 32'h0, 3'b100, rd, er, lat);
    total++; if (rd !== 32'h000000DE) $display("FAIL lbu_13: got %h want 000000de", rd); else passed++;
    xact(1'b0, 32'h12, 32'h0, 3'b001, rd, er, lat);
    total++; if (rd !== 32'hFFFFDEAD) $display("FAIL lh_12: got %h want ffffdead", rd); else passed++;
    xact(1'b1, 32'h11, 32'hAAAAAA55, 3'b000, rd, er, lat);
    total++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL sb_11_rsp: rdata=%h err=%b want 0/0", rd, er); else passed++;
    xact(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
    total++; if (rd !== 32'hDEAD55EF) $display("FAIL lw_after_sb: got %h want dead55ef", rd); else passed++;
    xact(1'b0, 32'h10, 32'h0, 3'b101, rd, er, lat);
    total++; if (rd !== 32'h000055EF) $display("FAIL lhu_10: got %h want 000055ef", rd); else passed++;
    xact(1'b1, 32'h8, 32'hFFFF1234, 3'b001, rd, er, lat);
    xact(1'b1, 32'hA, 32'h0000ABCD, 3'b001, rd, er, lat);
    xact(1'b0, 32'h8, 32'h0, 3'b010, rd, er, lat);
    total++; if (rd !== 32'hABCD1234) $display("FAIL sh_pair: got %h want abcd1234", rd); else passed++;
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, 32'h0, 32'hA5A5A5A5, 3'b010, rd, er, lat);
`ifdef DMEM_ERR_EN
    xact(1'b0, 32'h12, 32'h0, 3'b010, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL lw_misaligned: err=%b rdata=%h want 1/0", er, rd); else passed++;
    xact(1'b0, 32'h13, 32'h0, 3'b001, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL lh_misaligned: err=%b rdata=%h want 1/0", er, rd); else passed++;
    xact(1'b1, 32'h1000, 32'h11111111, 3'b010, rd, er, lat);
    total++; if (er !== 1'b1) $display("FAIL sw_oor_err: got %b want 1", er); else passed++;
    xact(1'b0, 32'h0, 32'h0, 3'b010, rd, er, lat);
    total++; if (rd !== 32'hA5A5A5A5 || er !== 1'b0) $display("FAIL oor_no_write: rdata=%h err=%b want a5a5a5a5/0", rd, er); else passed++;
    xact(1'b0, 32'h10, 32'h0, 3'b011, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL illegal_f3: err=%b rdata=%h want 1/0", er, rd); else passed++;
    xact(1'b1, 32'h10, 32'h0, 3'b100, rd, er, lat);
    total++; if (er !== 1'b1) $display("FAIL illegal_store_f3: got %b want 1", er); else passed++;
`else
    xact(1'b0, 32'h12, 32'h0, 3'b010, rd, er, lat);
    total++; if (er !== 1'b0 || rd !== 32'hDEAD55EF) $display("FAIL lw_misaligned: err=%b rdata=%h want 0/dead55ef", er, rd); else passed++;
    xact(1'b0, 32'h13, 32'h0, 3'b001, rd, er, lat);
    total++; if (er !== 1'b0 || rd !== 32'hFFFFDEAD) $display("FAIL lh_misaligned: err=%b rdata=%h want 0/ffffdead", er, rd); else passed++;
    xact(1'b1, 32'h1000, 32'h11111111, 3'b010, rd, er, lat);
    total++; if (er !== 1'b0) $display("FAIL sw_oor_err: got %b want 0", er); else passed++;
    xact(1'b0, 32'h0, 32'h0, 3'b010, rd, er, lat);
    total++; if (rd !== 32'h11111111) $display("FAIL oor_wrap: got %h want 11111111", rd); else passed++;
    xact(1'b0, 32'h10, 32'h0, 3'b011, rd, er, lat);
    total++; if (er !== 1'b0 || rd !== 32'hDEAD55EF) $display("FAIL illegal_f3: err=%b rdata=%h want 0/dead55ef", er, rd); else passed++;
    xact(1'b1, 32'h4, 32'h76543210, 3'b100, rd, er, lat);
    xact(1'b0, 32'h4, 32'h0, 3'b010, rd, er, lat);
    total++; if (rd !== 32'h76543210) $display("FAIL illegal_store_f3: got %h want 76543210", rd); else passed++;
`endif
  endtask

  task automatic test_backpressure;
    int n; int bad;
    rsp_ready = 1'b0;
    req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    total++; if (n !== 4) $display("FAIL bp_latency: got %0d want 4", n); else passed++;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD55EF || rsp_err !== 1'b0 || req_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    total++; if (bad !== 0) $display("FAIL bp_stable: %0d unstable cycles, want 0", bad); else passed++;
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD55EF) $display("FAIL bp_hold: valid=%b rdata=%h want 1/dead55ef", rsp_valid, rsp_rdata); else passed++;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL bp_release: valid=%b ready=%b want 0/1", rsp_valid, req_ready); else passed++;
  endtask

  task automatic test_reset_midop;
    logic [31:0] rd; logic er; int lat; int n; int seen;
    xact(1'b1, 32'h20, 32'h0, 3'b010, rd, er, lat);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_funct3 = 3'b010; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    total++; if (req_ready !== 1'b0) $display("FAIL midop_ready_low: got %b want 0", req_ready); else passed++;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    total++; if (seen !== 0) $display("FAIL midop_no_rsp: rsp_valid high %0d cycles, want 0", seen); else passed++;
    xact(1'b0, 32'h20, 32'h0, 3'b010, rd, er, lat);
    total++; if (rd !== 32'h0) $display("FAIL midop_not_written: got %h want 0", rd); else passed++;
    total++; if (lat !== 4) $display("FAIL midop_latency: got %0d want 4", lat); else passed++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_backpressure();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
